i2c_slave_reg_bridge: RTL and testbench
=======================================

Name: i2c_slave_reg_bridge

Overview:
- Sits directly downstream/upstream of i2c_slave: consumes its received-byte AXI stream and feeds its transmit-byte AXI stream.
- Turns I2C transactions into accesses on a simple req/ack register port with an auto-incrementing register pointer.
- Write frame: first ADDR_BYTES bytes set the pointer, MSB first. Each further byte writes reg[ptr], then ptr++.
- Read: each byte the I2C slave requests is fetched on demand from reg[ptr], then ptr++.

Parameters:
- ADDR_WIDTH, 8, register pointer width, legal 1..16. ADDR_BYTES = 1 if ADDR_WIDTH<=8, else 2.
- DATA_WIDTH, 8, register data width. Fixed at 8; elaboration error otherwise.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_axis_data_tdata  in  8  received byte (from i2c_slave m_axis_data)
- s_axis_data_tvalid  in  1  received byte valid
- s_axis_data_tready  out  1  bridge accepts received byte
- s_axis_data_tlast  in  1  last byte of write frame
- m_axis_data_tdata  out  8  byte to transmit (to i2c_slave s_axis_data)
- m_axis_data_tvalid  out  1  transmit byte valid
- m_axis_data_tready  in  1  i2c_slave requests a byte
- m_axis_data_tlast  out  1  tied 0
- bus_addressed  in  1  from i2c_slave; falling edge aborts pending read data and frame state
- reg_addr  out  ADDR_WIDTH  register address
- reg_wr_req  out  1  write request, held until reg_ack
- reg_wr_data  out  8  write data
- reg_rd_req  out  1  read request, held until reg_ack
- reg_rd_data  in  8  read data, valid with reg_ack
- reg_ack  in  1  completes the pending request
- busy  out  1  state != IDLE, or frame open

Behaviour:
- Async reset values: state=IDLE, ptr=0, byte_idx=0, frame_open=0.
- Reset outputs: m_axis_data_tvalid=0, m_axis_data_tdata=0, reg_wr_req=0, reg_rd_req=0, reg_addr=0, reg_wr_data=0, busy=0.
- States: IDLE, WR_REQ, RD_REQ, RD_HOLD.
- s_axis_data_tready is combinational: 1 only in IDLE and not rst. The block takes one byte per handshake.
- Frame tracking:
  - byte_idx counts accepted bytes of the current frame, saturating at ADDR_BYTES.
  - frame_open=1 after a byte with tlast=0; cleared by a byte with tlast=1 or a bus_addressed falling edge.
  - The next byte after a frame is closed restarts with byte_idx=0.
- Pointer bytes (byte_idx<ADDR_BYTES):
  - Shift into the pointer assembly register. When ADDR_BYTES is reached, ptr takes the low ADDR_WIDTH bits.
  - tlast on an incomplete pointer: discard the partial value; ptr unchanged.
  - No register access.
- Data bytes (byte_idx==ADDR_BYTES):
  - On accept at cycle N: reg_addr=ptr, reg_wr_data=byte, reg_wr_req=1 from N+1, state WR_REQ.
  - Each cycle with reg_ack=1 in WR_REQ: drop req next cycle, ptr<=ptr+1 (mod 2^ADDR_WIDTH), return to IDLE.
- Read:
  - In IDLE with m_axis_data_tready=1 and no s_axis byte offered: reg_addr=ptr, reg_rd_req=1 next cycle, state RD_REQ.
  - On reg_ack: latch reg_rd_data into m_axis_data_tdata; tvalid=1 next cycle; state RD_HOLD.
  - On tvalid&&tready handshake: tvalid=0, ptr++, return to IDLE.
  - Fetch is on demand by design. i2c_slave stretches SCL while waiting, and read side effects occur only for bytes actually requested.
- Simultaneous s_axis_data_tvalid and m_axis_data_tready in IDLE: the write byte wins.
- bus_addressed falling edge in RD_HOLD: drop tvalid, ptr unchanged, go to IDLE.
- bus_addressed falling edge in RD_REQ/WR_REQ: the request completes normally (no bus abort). For RD_REQ the returned data is discarded and ptr is unchanged.
- reg_ack outside WR_REQ/RD_REQ is ignored.
- Pointer wrap: 0xFF+1 -> 0x00 for ADDR_WIDTH=8.
- reg_ack may be high in the first cycle req is visible. Minimum round trip: 2 cycles per byte.
- Reset mid-operation: all requests drop immediately; no partial state is retained.

Decomposition:
- Package i2c_reg_bridge_pkg holds:
  - the state enum (IDLE/WR_REQ/RD_REQ/RD_HOLD);
  - the function addr_bytes(ADDR_WIDTH).
- No sub-module is needed; the pointer/frame logic stays inline.

Test Plan:
- Write frame 0x10, 0xAA, 0xBB(tlast) with reg_ack 1 cycle after req -> reg writes (0x10,0xAA), (0x11,0xBB); ptr=0x12; busy low afterwards.
- Pointer-only frame 0x20(tlast), then two reads with model reg[0x20]=0x5A, reg[0x21]=0xC3 -> m_axis bytes 0x5A, 0xC3; reg_rd_req issued only when tready high; ptr=0x22.
- Write frame 0xFF, 0x01, 0x02 -> writes at 0xFF and 0x00 (wrap); ptr=0x01.
- Read fetched, tvalid held, bus_addressed falls before tready -> tvalid drops, ptr unchanged; the next read re-fetches the same address.
- ADDR_WIDTH=16: frame 0x12, 0x34, 0x99 -> write 0x99 at 0x1234. Frame 0x56(tlast) -> ptr stays 0x1235.
- Async reset asserted while reg_wr_req high and reg_ack withheld -> reg_wr_req=0 at once, ptr=0; the first write after reset is a pointer byte.

Source files
------------

// File: rtl/i2c_reg_bridge_pkg.sv
// Shared types and helpers for the I2C-slave-to-register bridge.
package i2c_reg_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_REQ  = 2'd1,
        RD_REQ  = 2'd2,
        RD_HOLD = 2'd3
    } state_t;

    // Number of pointer bytes that open each write frame.
    function automatic int unsigned addr_bytes(input int unsigned addr_width);
        return (addr_width <= 32'd8) ? 32'd1 : 32'd2;
    endfunction

endpackage

// File: rtl/i2c_slave_reg_bridge.sv
// Bridges i2c_slave byte streams onto a req/ack register port with an
// auto-incrementing pointer; read bytes are fetched only when requested.
module i2c_slave_reg_bridge
    import i2c_reg_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_axis_data_tdata,
    input  logic                  s_axis_data_tvalid,
    output logic                  s_axis_data_tready,
    input  logic                  s_axis_data_tlast,
    output logic [7:0]            m_axis_data_tdata,
    output logic                  m_axis_data_tvalid,
    input  logic                  m_axis_data_tready,
    output logic                  m_axis_data_tlast,
    input  logic                  bus_addressed,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic                  reg_wr_req,
    output logic [7:0]            reg_wr_data,
    output logic                  reg_rd_req,
    input  logic [7:0]            reg_rd_data,
    input  logic                  reg_ack,
    output logic                  busy
);

    localparam int unsigned ADDR_BYTES = addr_bytes(ADDR_WIDTH);

    if (DATA_WIDTH != 8) begin : g_bad_data_width
        $error("i2c_slave_reg_bridge: DATA_WIDTH must be 8");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 16) begin : g_bad_addr_width
        $error("i2c_slave_reg_bridge: ADDR_WIDTH must be 1..16");
    end

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [1:0]            r_byte_idx;
    logic                  r_frame_open;
    logic [7:0]            r_ptr_asm;
    logic                  r_bus_addr_d;
    logic                  r_rd_discard;
    logic [7:0]            r_m_tdata;
    logic                  r_m_tvalid;
    logic [ADDR_WIDTH-1:0] r_reg_addr;
    logic                  r_wr_req;
    logic [7:0]            r_wr_data;
    logic                  r_rd_req;

    logic                  w_bus_fall;
    logic                  w_is_ptr_byte;
    logic                  w_ptr_done;
    logic [15:0]           w_ptr_full;

    assign w_bus_fall    = r_bus_addr_d && !bus_addressed;
    assign w_is_ptr_byte = (r_byte_idx < 2'(ADDR_BYTES));
    assign w_ptr_done    = (r_byte_idx == 2'(ADDR_BYTES - 1));
    assign w_ptr_full    = {r_ptr_asm, s_axis_data_tdata};

    assign s_axis_data_tready = (r_state == IDLE) && !rst;
    assign m_axis_data_tdata  = r_m_tdata;
    assign m_axis_data_tvalid = r_m_tvalid;
    assign m_axis_data_tlast  = 1'b0;
    assign reg_addr           = r_reg_addr;
    assign reg_wr_req         = r_wr_req;
    assign reg_wr_data        = r_wr_data;
    assign reg_rd_req         = r_rd_req;
    assign busy               = (r_state != IDLE) || r_frame_open;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_byte_idx   <= 2'd0;
            r_frame_open <= 1'b0;
            r_ptr_asm    <= 8'd0;
            r_bus_addr_d <= 1'b0;
            r_rd_discard <= 1'b0;
            r_m_tdata    <= 8'd0;
            r_m_tvalid   <= 1'b0;
            r_reg_addr   <= '0;
            r_wr_req     <= 1'b0;
            r_wr_data    <= 8'd0;
            r_rd_req     <= 1'b0;
        end else begin
            r_bus_addr_d <= bus_addressed;
            case (r_state)
                IDLE: begin
                    // A received byte takes priority over a transmit request.
                    if (s_axis_data_tvalid) begin
                        if (w_is_ptr_byte) begin
                            r_ptr_asm  <= s_axis_data_tdata;
                            r_byte_idx <= r_byte_idx + 2'd1;
                            if (w_ptr_done) begin
                                r_ptr <= ADDR_WIDTH'(w_ptr_full);
                            end
                        end else begin
                            r_reg_addr <= r_ptr;
                            r_wr_data  <= s_axis_data_tdata;
                            r_wr_req   <= 1'b1;
                            r_state    <= WR_REQ;
                        end
                        r_frame_open <= !s_axis_data_tlast;
                        if (s_axis_data_tlast) begin
                            r_byte_idx <= 2'd0;
                        end
                    end else if (m_axis_data_tready) begin
                        r_reg_addr   <= r_ptr;
                        r_rd_req     <= 1'b1;
                        r_rd_discard <= 1'b0;
                        r_state      <= RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (reg_ack) begin
                        r_wr_req <= 1'b0;
                        r_ptr    <= r_ptr + ADDR_WIDTH'(1);
                        r_state  <= IDLE;
                    end
                end
                RD_REQ: begin
                    // The access always completes; a bus abort only discards its data.
                    if (reg_ack) begin
                        r_rd_req <= 1'b0;
                        if (r_rd_discard || w_bus_fall) begin
                            r_state <= IDLE;
                        end else begin
                            r_m_tdata  <= reg_rd_data;
                            r_m_tvalid <= 1'b1;
                            r_state    <= RD_HOLD;
                        end
                    end else if (w_bus_fall) begin
                        r_rd_discard <= 1'b1;
                    end
                end
                RD_HOLD: begin
                    if (w_bus_fall) begin
                        r_m_tvalid <= 1'b0;
                        r_state    <= IDLE;
                    end else if (m_axis_data_tready) begin
                        r_m_tvalid <= 1'b0;
                        r_ptr      <= r_ptr + ADDR_WIDTH'(1);
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_bus_fall) begin
                r_frame_open <= 1'b0;
                r_byte_idx   <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_reg_bridge.sv
// Directed bench: an 8-bit-pointer and a 16-bit-pointer bridge, each backed
// by a register-file model that acks one cycle after a request appears.
module tb_i2c_slave_reg_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  s_tdata [2];
    logic        s_tvalid[2];
    logic        s_tlast [2];
    logic        s_tready[2];
    logic [7:0]  m_tdata [2];
    logic        m_tvalid[2];
    logic        m_tready[2];
    logic        m_tlast [2];
    logic        bus_addr[2];
    logic        wr_req  [2];
    logic [7:0]  wr_data [2];
    logic        rd_req  [2];
    logic [7:0]  rd_data [2];
    logic        ack     [2];
    logic        busy    [2];
    logic [7:0]  addr8;
    logic [15:0] addr16;
    bit          ack_hold;
    bit          mem_ready;

    logic [7:0] mem8 [256];
    logic [7:0] mem16[65536];

    int checks   = 0;
    int failures = 0;

    i2c_slave_reg_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .s_axis_data_tdata(s_tdata[0]), .s_axis_data_tvalid(s_tvalid[0]),
        .s_axis_data_tready(s_tready[0]), .s_axis_data_tlast(s_tlast[0]),
        .m_axis_data_tdata(m_tdata[0]), .m_axis_data_tvalid(m_tvalid[0]),
        .m_axis_data_tready(m_tready[0]), .m_axis_data_tlast(m_tlast[0]),
        .bus_addressed(bus_addr[0]), .reg_addr(addr8),
        .reg_wr_req(wr_req[0]), .reg_wr_data(wr_data[0]),
        .reg_rd_req(rd_req[0]), .reg_rd_data(rd_data[0]),
        .reg_ack(ack[0]), .busy(busy[0])
    );

    i2c_slave_reg_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut_w (
        .clk(clk), .rst(rst),
        .s_axis_data_tdata(s_tdata[1]), .s_axis_data_tvalid(s_tvalid[1]),
        .s_axis_data_tready(s_tready[1]), .s_axis_data_tlast(s_tlast[1]),
        .m_axis_data_tdata(m_tdata[1]), .m_axis_data_tvalid(m_tvalid[1]),
        .m_axis_data_tready(m_tready[1]), .m_axis_data_tlast(m_tlast[1]),
        .bus_addressed(bus_addr[1]), .reg_addr(addr16),
        .reg_wr_req(wr_req[1]), .reg_wr_data(wr_data[1]),
        .reg_rd_req(rd_req[1]), .reg_rd_data(rd_data[1]),
        .reg_ack(ack[1]), .busy(busy[1])
    );

    // Register-file model: contents default to addr^0x3C, ack one cycle after req.
    always_ff @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem8[i] <= 8'(i) ^ 8'h3C;
            for (int i = 0; i < 65536; i++) mem16[i] <= 8'(i) ^ 8'h3C;
            mem8[8'h20] <= 8'h5A;
            mem8[8'h21] <= 8'hC3;
            mem_ready   <= 1'b1;
            ack[0]      <= 1'b0;
            ack[1]      <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++)
                ack[i] <= (wr_req[i] || rd_req[i]) && !ack[i] && !ack_hold;
            if (wr_req[0] && ack[0]) mem8[addr8]   <= wr_data[0];
            if (wr_req[1] && ack[1]) mem16[addr16] <= wr_data[1];
        end
    end

    always_comb begin
        rd_data[0] = mem8[addr8];
        rd_data[1] = mem16[addr16];
    end

    function automatic logic [15:0] addr_of(input int w);
        return (w == 1) ? addr16 : {8'h00, addr8};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h expected=0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; offers one byte and returns at the negedge after the handshake.
    task automatic send_byte(input int w, input logic [7:0] d, input bit last);
        int n = 0;
        while (!s_tready[w] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tready_wait", 16'(s_tready[w]), 16'd1);
        s_tdata[w]  = d;
        s_tlast[w]  = last;
        s_tvalid[w] = 1'b1;
        @(negedge clk);
        s_tvalid[w] = 1'b0;
        s_tlast[w]  = 1'b0;
    endtask

    task automatic check_write(input int w, input bit exp_wr, input logic [15:0] ea,
                               input logic [7:0] ed, input bit exp_busy);
        int n = 0;
        if (exp_wr) begin
            chk("wr_req", 16'(wr_req[w]), 16'd1);
            chk("wr_addr", addr_of(w), ea);
            chk("wr_data", 16'(wr_data[w]), 16'(ed));
            while (wr_req[w] && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("wr_done", 16'(wr_req[w]), 16'd0);
        end else begin
            chk("no_wr_req", 16'(wr_req[w]), 16'd0);
        end
        chk("busy_after_byte", 16'(busy[w]), 16'(exp_busy));
    endtask

    task automatic do_read(input int w, input logic [15:0] ea, input logic [7:0] ed, input bit abort);
        int n = 0;
        repeat (2) @(negedge clk);
        chk("rd_req_idle", 16'(rd_req[w]), 16'd0);
        m_tready[w] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_req[w] && n < 20);
        chk("rd_req_wait", 16'(rd_req[w]), 16'd1);
        chk("rd_addr", addr_of(w), ea);
        m_tready[w] = 1'b0;
        n = 0;
        while (!m_tvalid[w] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("tvalid_wait", 16'(m_tvalid[w]), 16'd1);
        chk("rd_byte", 16'(m_tdata[w]), 16'(ed));
        if (abort) begin
            bus_addr[w] = 1'b0;
            @(negedge clk);
            bus_addr[w] = 1'b1;
            chk("abort_tvalid", 16'(m_tvalid[w]), 16'd0);
        end else begin
            m_tready[w] = 1'b1;
            @(negedge clk);
            m_tready[w] = 1'b0;
            chk("hs_tvalid", 16'(m_tvalid[w]), 16'd0);
        end
        chk("rd_busy", 16'(busy[w]), 16'd0);
    endtask

    typedef struct {
        logic [7:0] d;
        bit         last;
        bit         wr;
        logic [7:0] wa;
        logic [7:0] wd;
        bit         bsy;
        bit         rd;
        logic [7:0] ra;
        logic [7:0] rdv;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00};
        vecs[1] = '{8'hAA, 1'b0, 1'b1, 8'h10, 8'hAA, 1'b1, 1'b0, 8'h00, 8'h00};
        vecs[2] = '{8'hBB, 1'b1, 1'b1, 8'h11, 8'hBB, 1'b0, 1'b1, 8'h12, 8'h2E};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00};
        vecs[4] = '{8'h01, 1'b0, 1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00};
        vecs[5] = '{8'h02, 1'b1, 1'b1, 8'h00, 8'h02, 1'b0, 1'b1, 8'h01, 8'h3D};
        vecs[6] = '{8'h20, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h20, 8'h5A};

        for (int i = 0; i < 2; i++) begin
            s_tdata[i]  = 8'h00;
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
            m_tready[i] = 1'b0;
            bus_addr[i] = 1'b1;
        end
        ack_hold = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_wr_req", 16'(wr_req[0]), 16'd0);
        chk("rst_rd_req", 16'(rd_req[0]), 16'd0);
        chk("rst_tvalid", 16'(m_tvalid[0]), 16'd0);
        chk("rst_tdata", 16'(m_tdata[0]), 16'd0);
        chk("rst_addr", addr_of(0), 16'd0);
        chk("rst_wdata", 16'(wr_data[0]), 16'd0);
        chk("rst_busy", 16'(busy[0]), 16'd0);
        chk("rst_tready", 16'(s_tready[0]), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("tready_after_rst", 16'(s_tready[0]), 16'd1);
        chk("tlast_tied", 16'(m_tlast[0]), 16'd0);

        // Write frames, pointer wrap and pointer-only frame.
        for (int i = 0; i < 7; i++) begin
            send_byte(0, vecs[i].d, vecs[i].last);
            check_write(0, vecs[i].wr, 16'(vecs[i].wa), vecs[i].wd, vecs[i].bsy);
            if (vecs[i].rd) do_read(0, 16'(vecs[i].ra), vecs[i].rdv, 1'b0);
        end

        do_read(0, 16'h0021, 8'hC3, 1'b0);
        // Fetched byte abandoned by a bus release, then re-fetched from the same address.
        do_read(0, 16'h0022, 8'h1E, 1'b1);
        do_read(0, 16'h0022, 8'h1E, 1'b0);

        // 16-bit pointer bridge.
        send_byte(1, 8'h12, 1'b0);
        check_write(1, 1'b0, 16'h0000, 8'h00, 1'b1);
        send_byte(1, 8'h34, 1'b0);
        check_write(1, 1'b0, 16'h0000, 8'h00, 1'b1);
        send_byte(1, 8'h99, 1'b1);
        check_write(1, 1'b1, 16'h1234, 8'h99, 1'b0);
        send_byte(1, 8'h56, 1'b1);
        check_write(1, 1'b0, 16'h0000, 8'h00, 1'b0);
        do_read(1, 16'h1235, 8'h09, 1'b0);

        // Reset while a write request is stalled.
        send_byte(0, 8'h30, 1'b0);
        check_write(0, 1'b0, 16'h0000, 8'h00, 1'b1);
        ack_hold = 1'b1;
        send_byte(0, 8'h77, 1'b0);
        chk("stall_wr_req", 16'(wr_req[0]), 16'd1);
        chk("stall_addr", addr_of(0), 16'h0030);
        repeat (2) @(negedge clk);
        chk("stall_wr_held", 16'(wr_req[0]), 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_wr_req", 16'(wr_req[0]), 16'd0);
        chk("async_rst_busy", 16'(busy[0]), 16'd0);
        chk("async_rst_addr", addr_of(0), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        ack_hold = 1'b0;
        do_read(0, 16'h0000, 8'h02, 1'b0);
        send_byte(0, 8'h50, 1'b0);
        check_write(0, 1'b0, 16'h0000, 8'h00, 1'b1);
        send_byte(0, 8'h66, 1'b1);
        check_write(0, 1'b1, 16'h0050, 8'h66, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
